// File: rtl/kgp_alu_pkg.sv
// Shared constants for the KGP-RISC ALU path: opcode encodings and the add/sub sequencer states.
package kgp_alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_e;

endpackage

// File: rtl/CLA_16bit_withLCU.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a lookahead carry unit.
module CLA_16bit_withLCU (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] gen, prop, carry;
  logic [3:0]  grp_g, grp_p;
  logic [4:0]  grp_c;

  assign gen  = in1 & in2;
  assign prop = in1 ^ in2;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      grp_g[i] = gen[4*i+3]
               | (prop[4*i+3] & gen[4*i+2])
               | (prop[4*i+3] & prop[4*i+2] & gen[4*i+1])
               | (prop[4*i+3] & prop[4*i+2] & prop[4*i+1] & gen[4*i]);
      grp_p[i] = &prop[4*i +: 4];
    end
  end

  // Group carries from the LCU; bit carries are then resolved inside each group.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
    end
  end

  always_comb begin
    carry = '0;
    for (int i = 0; i < 4; i++) begin
      carry[4*i] = grp_c[i];
      for (int k = 1; k < 4; k++) begin
        carry[4*i+k] = gen[4*i+k-1] | (prop[4*i+k-1] & carry[4*i+k-1]);
      end
    end
  end

  assign sum   = prop ^ carry;
  assign c_out = grp_c[4];

endmodule

// File: rtl/seq_addsub32.sv
// Two-pass 32-bit add/subtract: one shared 16-bit CLA computes the low half, then the high half.
module seq_addsub32
  import kgp_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned Half = WIDTH / 2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             op_q, op_d;
  logic [Half-1:0]  sum_lo_q, sum_lo_d;
  logic             c_mid_q, c_mid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, overflow_q, overflow_d, zero_q, zero_d, done_q, done_d;

  logic [Half-1:0]  add_in1, add_in2, add_sum;
  logic             add_cin, add_cout;

  // Operand-side mux picks the half being processed this cycle.
  always_comb begin
    if (state_q == S_HIGH) begin
      add_in1 = op_a_q[WIDTH-1:Half];
      add_in2 = op_b_q[WIDTH-1:Half];
      add_cin = c_mid_q;
    end else begin
      add_in1 = op_a_q[Half-1:0];
      add_in2 = op_b_q[Half-1:0];
      add_cin = op_q;
    end
  end

  CLA_16bit_withLCU u_cla (
    .in1   (add_in1),
    .in2   (add_in2),
    .c_in  (add_cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_d       = op_q;
    sum_lo_d   = sum_lo_q;
    c_mid_d    = c_mid_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = (op == OP_SUB) ? ~b : b;
          op_d    = op;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        sum_lo_d = add_sum;
        c_mid_d  = add_cout;
        state_d  = S_HIGH;
      end
      S_HIGH: begin
        result_d   = {add_sum, sum_lo_q};
        carry_d    = add_cout;
        overflow_d = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                     (add_sum[Half-1] != op_a_q[WIDTH-1]);
        zero_d     = ({add_sum, sum_lo_q} == '0);
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_q       <= 1'b0;
      sum_lo_q   <= '0;
      c_mid_q    <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_q       <= op_d;
      sum_lo_q   <= sum_lo_d;
      c_mid_q    <= c_mid_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_seq_addsub32.sv
// Self-checking bench for seq_addsub32: directed table, handshake/reset sequences, random vs model.
module tb_seq_addsub32;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [31:0] a, b;
  logic        busy, done, carry, overflow, zero;
  logic [31:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_addsub32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 33-bit arithmetic and signed range check.
  function automatic vec_t model(input logic [31:0] x, input logic [31:0] y, input logic o);
    vec_t r;
    logic [32:0] full;
    longint sx, sy, sr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o) begin
      full = {1'b0, x} + {1'b0, ~y} + 33'd1;
      sr   = sx - sy;
    end else begin
      full = {1'b0, x} + {1'b0, y};
      sr   = sx + sy;
    end
    r.a = x; r.b = y; r.op = o;
    r.res = full[31:0];
    r.c   = full[32];
    r.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.z   = (full[31:0] == 32'd0);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where done is high.
  task automatic do_op(input vec_t v, input string name);
    start = 1'b1; a = v.a; b = v.b; op = v.op;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = $urandom_range(0, 1);
    chk({name, ".busy1"}, {31'd0, busy}, 32'd1);
    chk({name, ".done1"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    chk({name, ".busy2"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({name, ".done"}, {31'd0, done}, 32'd1);
    chk({name, ".busy3"}, {31'd0, busy}, 32'd0);
    chk({name, ".res"}, result, v.res);
    chk({name, ".c"}, {31'd0, carry}, {31'd0, v.c});
    chk({name, ".v"}, {31'd0, overflow}, {31'd0, v.v});
    chk({name, ".z"}, {31'd0, zero}, {31'd0, v.z});
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".busy"}, {31'd0, busy}, 32'd0);
    chk({name, ".done"}, {31'd0, done}, 32'd0);
    chk({name, ".res"}, result, 32'd0);
    chk({name, ".z"}, {31'd0, zero}, 32'd1);
    chk({name, ".c"}, {31'd0, carry}, 32'd0);
    chk({name, ".v"}, {31'd0, overflow}, 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v, w;
    tbl[0] = '{32'd1,          32'd2,          1'b0, 32'd3,          1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h0000FFFF,   32'd1,          1'b0, 32'h00010000,   1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'd0,          1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'd5,          32'd7,          1'b1, 32'hFFFFFFFE,   1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'd7,          32'd5,          1'b1, 32'd2,          1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h7FFFFFFF,   32'd1,          1'b0, 32'h80000000,   1'b0, 1'b1, 1'b0};
    tbl[6] = '{32'h80000000,   32'd1,          1'b1, 32'h7FFFFFFF,   1'b1, 1'b1, 1'b0};
    tbl[7] = '{32'h12345678,   32'h12345678,   1'b1, 32'd0,          1'b1, 1'b0, 1'b1};

    rst = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i], $sformatf("tbl%0d", i));
      @(negedge clk);
      chk($sformatf("tbl%0d.hold", i), result, tbl[i].res);
      chk($sformatf("tbl%0d.pulse", i), {31'd0, done}, 32'd0);
    end

    // start during busy must be ignored
    start = 1'b1; a = 32'd100; b = 32'd23; op = 1'b0;
    @(negedge clk);
    a = 32'hDEAD0000; b = 32'h0000BEEF; op = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ign.done", {31'd0, done}, 32'd1);
    chk("ign.res", result, 32'd123);
    @(negedge clk);
    chk("ign.nodone", {31'd0, done}, 32'd0);
    chk("ign.idle", {31'd0, busy}, 32'd0);

    // back-to-back: next start in the done cycle
    v = model(32'h00010001, 32'h0000FFFF, 1'b0);
    w = model(32'h00000010, 32'h00000020, 1'b1);
    do_op(v, "b2b0");
    do_op(w, "b2b1");
    @(negedge clk);

    // reset in LOW, then in HIGH
    for (int k = 1; k <= 2; k++) begin
      start = 1'b1; a = 32'h11111111; b = 32'h22222222; op = 1'b0;
      @(negedge clk);
      start = 1'b0;
      if (k == 2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals($sformatf("rst%0d", k));
      rst = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("rst%0d.nodone", k), {31'd0, done}, 32'd0);
      end
      do_op(tbl[0].op ? tbl[0] : model(32'd9, 32'd6, 1'b0), $sformatf("rst%0d.after", k));
      @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom;
      if (i % 8 == 1) x = 32'h80000000;
      if (i % 8 == 2) y = 32'hFFFFFFFF;
      if (i % 8 == 3) y = x;
      v = model(x, y, 1'($urandom_range(0, 1)));
      do_op(v, $sformatf("rnd%0d", i));
      if (i % 3 == 0) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
